// File: rtl/register_file_ppp_pkg.sv
// Shared constants, field encodings and mask helpers for the PPP register file.
package register_file_ppp_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    // Participation field: which part of the register a write touches.
    typedef enum logic [2:0] {
        PPP_A = 3'b000,   // all bits
        PPP_U = 3'b001,   // upper half, bits 0:31
        PPP_D = 3'b010,   // lower half, bits 32:63
        PPP_E = 3'b011,   // even-numbered units
        PPP_O = 3'b100    // odd-numbered units
    } ppp_e;

    // Unit width used by the even/odd participation modes.
    typedef enum logic [1:0] {
        WW_B = 2'b00,     // byte
        WW_H = 2'b01,     // halfword
        WW_W = 2'b10,     // word
        WW_D = 2'b11      // doubleword
    } ww_e;

    // Parity of the unit that contains a given MSB-first bit number.
    // A doubleword unit always covers the whole register, so it is unit 0.
    function automatic logic unit_is_odd(input logic [5:0] bit_num, input logic [1:0] ww);
        logic odd;
        case (ww)
            WW_B:    odd = bit_num[3];
            WW_H:    odd = bit_num[4];
            WW_W:    odd = bit_num[5];
            default: odd = 1'b0;
        endcase
        return odd;
    endfunction

endpackage

// File: rtl/register_file_ppp_mask_gen.sv
// Combinational write-mask generator: (PPP, WW) -> 64-bit participation mask.
// Mask bit DATA_W-1 corresponds to architectural bit 0 (the MSB).
module reg_file_mask_gen
    import register_file_ppp_pkg::*;
(
    input  logic [2:0]        ppp,
    input  logic [1:0]        ww,
    output logic [DATA_W-1:0] mask
);

    // Decode the participation field into a per-bit write enable.
    always_comb begin
        mask = '0;
        case (ppp)
            PPP_A: mask = '1;
            PPP_U: mask = {{(DATA_W/2){1'b1}}, {(DATA_W/2){1'b0}}};
            PPP_D: mask = {{(DATA_W/2){1'b0}}, {(DATA_W/2){1'b1}}};
            PPP_E: begin
                for (int j = 0; j < DATA_W; j++) begin
                    mask[j] = ~unit_is_odd(6'(DATA_W - 1 - j), ww);
                end
            end
            PPP_O: begin
                for (int j = 0; j < DATA_W; j++) begin
                    mask[j] = unit_is_odd(6'(DATA_W - 1 - j), ww);
                end
            end
            default: mask = '0;   // reserved codes write nothing
        endcase
    end

endmodule

// File: rtl/register_file_ppp.sv
// 32 x 64-bit register file: two combinational read ports with same-cycle
// write forwarding, one masked synchronous write port, async active-low reset.
module register_file_ppp
    import register_file_ppp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] Din,
    input  logic [2:0]        PPP,
    input  logic [1:0]        WW,
    input  logic [ADDR_W-1:0] read1_addr,
    input  logic [ADDR_W-1:0] read2_addr,
    output logic [DATA_W-1:0] Dout1,
    output logic [DATA_W-1:0] Dout2
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] wr_val;
    logic              wr_live;

    // One mask serves both the storage update and the forwarding path.
    reg_file_mask_gen u_mask_gen (
        .ppp  (PPP),
        .ww   (WW),
        .mask (mask)
    );

    // Merge new data into the addressed register; a write is only live out of reset.
    always_comb begin
        wr_live = write_en & reset;
        wr_val  = (Din & mask) | (regs_q[write_addr] & ~mask);
        regs_d  = regs_q;
        if (wr_live) begin
            regs_d[write_addr] = wr_val;
        end
    end

    // Storage array; reset clears every register immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes: forward the merged value when reading the register being written.
    always_comb begin
        Dout1 = regs_q[read1_addr];
        Dout2 = regs_q[read2_addr];
        if (wr_live && (read1_addr == write_addr)) begin
            Dout1 = wr_val;
        end
        if (wr_live && (read2_addr == write_addr)) begin
            Dout2 = wr_val;
        end
    end

endmodule

// File: tb/tb_register_file_ppp.sv
// Self-checking bench for register_file_ppp: directed cases from the field
// definitions plus randomized traffic against an array-based reference model.
module tb_register_file_ppp;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [63:0] Din;
    logic [2:0]  PPP;
    logic [1:0]  WW;
    logic [4:0]  read1_addr;
    logic [4:0]  read2_addr;
    logic [63:0] Dout1;
    logic [63:0] Dout2;

    logic [63:0] model [32];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    register_file_ppp dut (
        .clk        (clk),
        .reset      (reset),
        .write_en   (write_en),
        .write_addr (write_addr),
        .Din        (Din),
        .PPP        (PPP),
        .WW         (WW),
        .read1_addr (read1_addr),
        .read2_addr (read2_addr),
        .Dout1      (Dout1),
        .Dout2      (Dout2)
    );

    // Reference mask built directly from the architectural bit numbering:
    // architectural bit k (0 = MSB) lives at vector index 63-k.
    function automatic logic [63:0] ref_mask(input logic [2:0] ppp, input logic [1:0] ww);
        logic [63:0] m;
        int          size;
        int          unit;
        logic        sel;
        m    = '0;
        size = 8 << ww;
        for (int k = 0; k < 64; k++) begin
            unit = k / size;
            case (ppp)
                3'd0:    sel = 1'b1;
                3'd1:    sel = (k < 32);
                3'd2:    sel = (k >= 32);
                3'd3:    sel = (unit % 2 == 0);
                3'd4:    sel = (unit % 2 == 1);
                default: sel = 1'b0;
            endcase
            m[63-k] = sel;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One write cycle: check forwarded reads before the edge, then the stored value after.
    task automatic do_write(input logic [4:0] addr, input logic [63:0] din,
                            input logic [2:0] ppp, input logic [1:0] ww,
                            input logic [4:0] r1, input logic [4:0] r2, input string tag);
        logic [63:0] merged;
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = addr;
        Din        = din;
        PPP        = ppp;
        WW         = ww;
        read1_addr = r1;
        read2_addr = r2;
        #1;
        merged = (din & ref_mask(ppp, ww)) | (model[addr] & ~ref_mask(ppp, ww));
        check({tag, "_fwd1"}, Dout1, (r1 == addr) ? merged : model[r1]);
        check({tag, "_fwd2"}, Dout2, (r2 == addr) ? merged : model[r2]);
        @(posedge clk);
        model[addr] = merged;
        #1;
        write_en = 1'b0;
    endtask

    task automatic read_check(input logic [4:0] r1, input logic [4:0] r2, input string tag);
        @(negedge clk);
        write_en   = 1'b0;
        read1_addr = r1;
        read2_addr = r2;
        #1;
        check({tag, "_rd1"}, Dout1, model[r1]);
        check({tag, "_rd2"}, Dout2, model[r2]);
    endtask

    typedef struct {
        logic [2:0]  ppp;
        logic [1:0]  ww;
        logic [63:0] exp;
    } dir_t;

    dir_t dir_tab [8];

    initial begin
        logic [63:0] tmp;
        logic [4:0]  a;
        logic [4:0]  r1;
        logic [4:0]  r2;

        dir_tab[0] = '{3'b001, 2'b00, 64'hFFFF_FFFF_0000_0000};
        dir_tab[1] = '{3'b010, 2'b11, 64'h0000_0000_FFFF_FFFF};
        dir_tab[2] = '{3'b011, 2'b00, 64'hFF00_FF00_FF00_FF00};
        dir_tab[3] = '{3'b100, 2'b00, 64'h00FF_00FF_00FF_00FF};
        dir_tab[4] = '{3'b011, 2'b01, 64'hFFFF_0000_FFFF_0000};
        dir_tab[5] = '{3'b100, 2'b10, 64'h0000_0000_FFFF_FFFF};
        dir_tab[6] = '{3'b011, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF};
        dir_tab[7] = '{3'b100, 2'b11, 64'h0000_0000_0000_0000};

        for (int i = 0; i < 32; i++) model[i] = '0;

        // Reset held for two cycles, with a write attempt that must be ignored.
        reset      = 1'b0;
        write_en   = 1'b1;
        write_addr = 5'd3;
        Din        = '1;
        PPP        = 3'b000;
        WW         = 2'b11;
        read1_addr = 5'd3;
        read2_addr = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        check("reset_wr_fwd1", Dout1, 64'h0);
        check("reset_wr_fwd2", Dout2, 64'h0);
        write_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read1_addr = 5'(i);
            read2_addr = 5'(31 - i);
            #1;
            check("reset_rd1", Dout1, 64'h0);
            check("reset_rd2", Dout2, 64'h0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Full writes with port 2 tracking the write address.
        for (int i = 0; i < 32; i++) begin
            tmp = 64'h8000_0000_0000_0000 | 64'(i + 1);
            do_write(5'(i), tmp, 3'b000, 2'b11, 5'($urandom_range(0, 31)), 5'(i), "full");
            check("full_fwd_din", Dout2, tmp);
        end
        for (int i = 0; i < 32; i++) begin
            read_check(5'(i), 5'(31 - i), "sweep");
            check("sweep_const", Dout1, 64'h8000_0000_0000_0000 | 64'(i + 1));
        end

        // Directed mask shapes: preset to zero, write all-ones, compare to table.
        for (int t = 0; t < 8; t++) begin
            a = 5'($urandom_range(0, 31));
            do_write(a, 64'h0, 3'b000, 2'b00, a, a, "preset");
            do_write(a, '1, dir_tab[t].ppp, dir_tab[t].ww, a, 5'(a + 1), "dir");
            read_check(a, a, "dir_after");
            check("dir_table", Dout1, dir_tab[t].exp);
        end

        // Reserved codes: register and forwarded value keep the old contents.
        for (int t = 0; t < 6; t++) begin
            a   = 5'($urandom_range(0, 31));
            tmp = {$urandom, $urandom};
            do_write(a, tmp, 3'b000, 2'b11, a, a, "rsv_preset");
            do_write(a, '1, 3'(5 + t % 3), 2'($urandom_range(0, 3)), a, a, "rsv");
            check("rsv_fwd_old", Dout1, tmp);
            read_check(a, a, "rsv_after");
            check("rsv_kept", Dout2, tmp);
        end

        // Randomized traffic, with read addresses often colliding with the write.
        for (int n = 0; n < 400; n++) begin
            a  = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 4) == 0) begin
                read_check(r1, r2, "rand_idle");
            end else begin
                do_write(a, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
                         2'($urandom_range(0, 3)), r1, r2, "rand");
            end
        end
        for (int i = 0; i < 32; i++) read_check(5'(i), 5'(i ^ 5'h1F), "final_sweep");

        // Asynchronous reset between edges while a write is pending.
        @(negedge clk);
        write_en   = 1'b1;
        write_addr = 5'd7;
        Din        = '1;
        PPP        = 3'b000;
        WW         = 2'b11;
        read1_addr = 5'd7;
        read2_addr = 5'd12;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_rd1", Dout1, 64'h0);
        check("async_rst_rd2", Dout2, 64'h0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(posedge clk);
        #1;
        check("async_rst_hold", Dout1, 64'h0);
        @(negedge clk);
        write_en = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 32; i++) read_check(5'(i), 5'(31 - i), "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
